control_sequencer: RTL and testbench
====================================

# control_sequencer

Hard-wired control unit that sits directly upstream of the datapath. It accepts one instruction word per handshake and steps through T-states, driving the datapath's register-enable, tri-state-out and immediate lines for exactly one cycle per micro-step. It reports completion, illegal opcodes and a retired-instruction count. It replaces hand-sequenced control in datapath benches.

## Interface

Parameters:
- DATA_W, 32, width of the immediate buses driven to the datapath.
- IMM_W, 16, width of the instruction immediate field; sign-extended to DATA_W.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- clear  in  1  asynchronous, active-low reset.
- instr  in  32  instruction word: opcode = instr[31:28], imm = instr[IMM_W-1:0]; all other bits ignored.
- instr_valid  in  1  upstream has an instruction on instr.
- instr_ready  out  1  sequencer can accept an instruction.
- RAin, RBin, RZin  out  1 each  datapath register A/B/Z load enables.
- RAout, RBout, RZout  out  1 each  datapath register A/B/Z bus drive enables.
- RegisterAImmediate  out  DATA_W  immediate loaded into A.
- AddImmediate  out  DATA_W  immediate operand to the adder.
- done  out  1  one-cycle pulse when an instruction completes (legal or illegal).
- err  out  1  one-cycle pulse, coincident with done, for an illegal opcode.
- retired  out  CNT_W  count of completed legal instructions.

## Operation

- Opcodes, with sext = imm sign-extended to DATA_W:
  - 0x0 NOP: one T-step; no controls asserted.
  - 0x1 LDIA: T0 asserts RAin and RegisterAImmediate = sext.
  - 0x2 ADDIZ: T0 asserts RAout, RZin and AddImmediate = sext.
  - 0x3 MVBZ: T0 asserts RZout and RBin.
  - 0x4 ADDIB: T0 as ADDIZ, then T1 as MVBZ.
  - 0x5–0xF: illegal. No T-step; go directly to DONE with err.
- States: IDLE, T0, T1, DONE.
  - IDLE -> T0 on instr_valid && instr_ready; instr is latched into an internal IR at that edge.
  - IDLE -> DONE instead when the latched opcode is illegal.
  - T0 -> T1 for ADDIB only; otherwise T0 -> DONE.
  - T1 -> DONE.
  - DONE -> IDLE unconditionally.
- All datapath control outputs are decoded from registered state and IR only, never from instr directly.
- Outside their active T-step, every control output is 0 and both immediate buses are 0.
- At most one *out enable is high in any cycle (single-bus rule).
- instr_ready = 1 only in IDLE with clear deasserted.
  - instr is ignored in every other state; no queuing.
  - A valid instruction held across DONE is accepted on the first IDLE edge.
- retired increments by 1 in DONE for legal opcodes (including NOP). It wraps from 2^CNT_W-1 to 0 and does not increment on err.

## Timing

- Reset (clear low), asynchronously and immediately:
  - state = IDLE, IR = 0, retired = 0.
  - done = err = 0, all *in/*out = 0, both immediates = 0, instr_ready = 0.
- instr_ready rises in the first cycle after clear deasserts.
- Accept at rising edge k:
  - T0 is the cycle k..k+1; the datapath captures at edge k+1.
  - Single-step op: done high in cycle k+1..k+2, instr_ready high again from edge k+2. Issue interval is 3 cycles.
  - ADDIB: T1 is cycle k+1..k+2, done in k+2..k+3, issue interval 4 cycles.
  - Illegal op: done and err in cycle k..k+1, issue interval 2 cycles.
- Clear asserted mid-instruction: the instruction is abandoned with no done pulse. Any control high at that moment drops immediately, and retired is cleared.
- retired updates at the edge ending DONE, so the new value is visible in the IDLE cycle.

## Test plan

- Reset: clear low mid-T0 of LDIA -> RAin and RegisterAImmediate drop to 0 without waiting for a clock edge; retired = 0; instr_ready = 0 until one edge after release.
- LDIA 5: instr = 0x1000_0005 -> one cycle with RAin = 1 and RegisterAImmediate = 0x0000_0005; done the next cycle; retired = 1.
- ADDIB 5 after LDIA 5: instr = 0x4000_0005 -> T0 has RAout, RZin and AddImmediate = 5, then T1 has RZout and RBin. With the datapath attached, B = 10 after the sequence; done on the third cycle after accept.
- Sign extension: LDIA imm 0xFFFB -> RegisterAImmediate = 0xFFFF_FFFB.
- Illegal 0x9000_0000 -> done and err together in the cycle after accept; no control asserted; retired unchanged.
- Back-to-back with instr_valid held high for 5 NOPs -> accepts exactly every 3 cycles; retired = 5; never two *out enables high at once. Separately, preload retired to 0xFFFF and complete one legal instruction -> retired = 0x0000.

Source files
------------

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Hard-wired control unit for the datapath. It accepts one instruction per
// instr_valid/instr_ready handshake, latches it into an internal IR and steps
// through the T-states IDLE -> T0 [-> T1] -> DONE. Each micro-step drives the
// register load/drive enables and immediates for exactly one cycle. It reports
// completion (done), illegal opcodes (err) and a retired-instruction count.
//
// Ports:
//   clock               in   single clock, rising-edge active
//   clear               in   asynchronous active-low reset
//   instr[31:0]         in   instruction: opcode = [31:28], imm = [IMM_W-1:0]
//   instr_valid         in   upstream offers an instruction
//   instr_ready         out  sequencer is idle and can accept
//   RAin/RBin/RZin      out  register A/B/Z load enables
//   RAout/RBout/RZout   out  register A/B/Z bus drive enables
//   RegisterAImmediate  out  sign-extended immediate loaded into A
//   AddImmediate        out  sign-extended immediate adder operand
//   done                out  one-cycle completion pulse
//   err                 out  one-cycle pulse with done for an illegal opcode
//   retired[CNT_W-1:0]  out  count of completed legal instructions (wraps)
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic              RAin,
  output logic              RBin,
  output logic              RZin,
  output logic              RAout,
  output logic              RBout,
  output logic              RZout,
  output logic [DATA_W-1:0] RegisterAImmediate,
  output logic [DATA_W-1:0] AddImmediate,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  retired
);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LDIA  = 4'h1;
  localparam logic [3:0] OP_ADDIZ = 4'h2;
  localparam logic [3:0] OP_MVBZ  = 4'h3;
  localparam logic [3:0] OP_ADDIB = 4'h4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [IMM_W+3:0]       r_ir;          // {opcode, imm}; other instr bits are not kept
  logic                   r_live;        // low until the first edge after clear releases
  logic [CNT_W-1:0]       r_retired;

  logic                   w_accept;
  logic                   w_in_illegal;
  logic [3:0]             w_op;
  logic                   w_illegal;
  logic signed [IMM_W-1:0] w_imm;
  logic [DATA_W-1:0]      w_sext;
  logic                   w_unused_instr;

  // Only opcode and imm are architecturally meaningful.
  assign w_unused_instr = ^instr;

  assign instr_ready  = r_live && (r_state == S_IDLE);
  assign w_accept     = instr_valid && instr_ready;
  assign w_in_illegal = (instr[31:28] > OP_ADDIB);

  assign w_op      = r_ir[IMM_W+3:IMM_W];
  assign w_illegal = (w_op > OP_ADDIB);
  assign w_imm     = r_ir[IMM_W-1:0];
  // Size cast of a signed operand sign-extends.
  assign w_sext    = DATA_W'(w_imm);

  assign retired   = r_retired;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state   <= S_IDLE;
      r_ir      <= '0;
      r_live    <= 1'b0;
      r_retired <= '0;
    end else begin
      r_live  <= 1'b1;
      r_state <= w_state_next;
      if (w_accept) begin
        r_ir <= {instr[31:28], instr[IMM_W-1:0]};
      end
      if ((r_state == S_DONE) && !w_illegal) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  // Next state and control decode. Outputs depend only on r_state and r_ir,
  // so the async reset forcing r_state to IDLE drops every control at once.
  always_comb begin
    w_state_next       = r_state;
    RAin               = 1'b0;
    RBin               = 1'b0;
    RZin               = 1'b0;
    RAout              = 1'b0;
    RBout              = 1'b0;
    RZout              = 1'b0;
    RegisterAImmediate = '0;
    AddImmediate       = '0;
    done               = 1'b0;
    err                = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          // Illegal opcodes skip the T-steps entirely.
          w_state_next = w_in_illegal ? S_DONE : S_T0;
        end
      end
      S_T0: begin
        w_state_next = (w_op == OP_ADDIB) ? S_T1 : S_DONE;
        case (w_op)
          OP_LDIA: begin
            RAin               = 1'b1;
            RegisterAImmediate = w_sext;
          end
          OP_ADDIZ, OP_ADDIB: begin
            RAout        = 1'b1;
            RZin         = 1'b1;
            AddImmediate = w_sext;
          end
          OP_MVBZ: begin
            RZout = 1'b1;
            RBin  = 1'b1;
          end
          default: ;  // OP_NOP: a bare T-step
        endcase
      end
      S_T1: begin
        // Only ADDIB reaches T1: second half moves Z into B.
        w_state_next = S_DONE;
        RZout        = 1'b1;
        RBin         = 1'b1;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
        done         = 1'b1;
        err          = w_illegal;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic        RAin, RBin, RZin, RAout, RBout, RZout;
  logic [31:0] RegisterAImmediate, AddImmediate;
  logic        done, err;
  logic [15:0] retired;

  // Second instance with a tiny counter to exercise wrap-around cheaply.
  logic [31:0] instr2 = '0;
  logic        instr_valid2 = 1'b0;
  logic        instr_ready2;
  logic        ra2, rb2, rz2, rao2, rbo2, rzo2, done2, err2;
  logic [31:0] rega2, add2;
  logic [2:0]  retired2;

  control_sequencer #(.DATA_W(32), .IMM_W(16), .CNT_W(16)) dut (
    .clock(clock), .clear(clear), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .RAin(RAin), .RBin(RBin), .RZin(RZin),
    .RAout(RAout), .RBout(RBout), .RZout(RZout),
    .RegisterAImmediate(RegisterAImmediate), .AddImmediate(AddImmediate),
    .done(done), .err(err), .retired(retired)
  );

  control_sequencer #(.DATA_W(32), .IMM_W(16), .CNT_W(3)) dut_wrap (
    .clock(clock), .clear(clear), .instr(instr2), .instr_valid(instr_valid2),
    .instr_ready(instr_ready2), .RAin(ra2), .RBin(rb2), .RZin(rz2),
    .RAout(rao2), .RBout(rbo2), .RZout(rzo2),
    .RegisterAImmediate(rega2), .AddImmediate(add2),
    .done(done2), .err(err2), .retired(retired2)
  );

  always #5 clock = ~clock;

  // Minimal datapath: A/B/Z registers on a shared bus, Z loads bus + AddImmediate.
  logic [31:0] dp_a = '0, dp_b = '0, dp_z = '0, dp_bus;
  always_comb dp_bus = RAout ? dp_a : (RZout ? dp_z : (RBout ? dp_b : 32'h0));
  always @(posedge clock) begin
    if (RAin) dp_a <= RegisterAImmediate;
    if (RZin) dp_z <= dp_bus + AddImmediate;
    if (RBin) dp_b <= dp_bus;
  end

  typedef struct {
    logic [31:0] instr;
    logic [5:0]  ctl0;      // {RAin,RBin,RZin,RAout,RBout,RZout}
    logic [31:0] rega0;
    logic [31:0] add0;
    logic        two_step;
    logic [5:0]  ctl1;
    logic        illegal;
  } vec_t;

  typedef struct {
    logic [5:0]  ctl;
    logic [31:0] rega;
    logic [31:0] add;
    logic        done;
    logic        err;
    logic        rdy;
    logic [15:0] ret;
  } obs_t;

  int   total = 0;
  int   bad = 0;
  obs_t sb[$];
  logic [15:0] exp_ret = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_obs(input obs_t o);
    check("ctl", {26'd0, RAin, RBin, RZin, RAout, RBout, RZout}, {26'd0, o.ctl});
    check("rega_imm", RegisterAImmediate, o.rega);
    check("add_imm", AddImmediate, o.add);
    check("done", {31'd0, done}, {31'd0, o.done});
    check("err", {31'd0, err}, {31'd0, o.err});
    check("ready", {31'd0, instr_ready}, {31'd0, o.rdy});
    check("retired", {16'd0, retired}, {16'd0, o.ret});
    check("single_bus", {31'd0, ($countones({RAout, RBout, RZout}) <= 1)}, 32'd1);
  endtask

  // Hold instr_valid for n NOPs on one of the instances and check the issue gap.
  task automatic run_nops(input int which, input int n);
    int accepts = 0;
    int last = -1;
    logic rdy;
    @(negedge clock);
    if (which == 0) begin instr = 32'h0; instr_valid = 1'b1; end
    else begin instr2 = 32'h0; instr_valid2 = 1'b1; end
    for (int c = 0; c < 60 && accepts < n; c++) begin
      rdy = (which == 0) ? instr_ready : instr_ready2;
      if (rdy) begin
        if (last >= 0) check("nop_gap", c - last, 3);
        last = c;
        accepts++;
      end
      check("b2b_single_bus", {31'd0, ($countones({RAout, RBout, RZout}) <= 1)}, 32'd1);
      @(negedge clock);
    end
    instr_valid = 1'b0;
    instr_valid2 = 1'b0;
    check("nop_accepts", accepts, n);
    @(posedge clock);
    @(posedge clock);
    #1;
  endtask

  vec_t vecs[10];

  initial begin
    vec_t v;
    obs_t o;

    vecs[0] = '{32'h1000_0005, 6'b100000, 32'h0000_0005, 32'h0, 1'b0, 6'b0, 1'b0};      // LDIA 5
    vecs[1] = '{32'h4000_0005, 6'b001100, 32'h0, 32'h0000_0005, 1'b1, 6'b010001, 1'b0}; // ADDIB 5
    vecs[2] = '{32'h1000_FFFB, 6'b100000, 32'hFFFF_FFFB, 32'h0, 1'b0, 6'b0, 1'b0};      // LDIA -5
    vecs[3] = '{32'h9000_0000, 6'b000000, 32'h0, 32'h0, 1'b0, 6'b0, 1'b1};              // illegal
    vecs[4] = '{32'h2ABC_8000, 6'b001100, 32'h0, 32'hFFFF_8000, 1'b0, 6'b0, 1'b0};      // ADDIZ -32768
    vecs[5] = '{32'h3000_1234, 6'b010001, 32'h0, 32'h0, 1'b0, 6'b0, 1'b0};              // MVBZ
    vecs[6] = '{32'h0FFF_FFFF, 6'b000000, 32'h0, 32'h0, 1'b0, 6'b0, 1'b0};              // NOP
    vecs[7] = '{32'hF000_0001, 6'b000000, 32'h0, 32'h0, 1'b0, 6'b0, 1'b1};              // illegal
    vecs[8] = '{32'h2000_7FFF, 6'b001100, 32'h0, 32'h0000_7FFF, 1'b0, 6'b0, 1'b0};      // ADDIZ max
    vecs[9] = '{32'h5000_0000, 6'b000000, 32'h0, 32'h0, 1'b0, 6'b0, 1'b1};              // illegal

    // Reset: real falling edge on clear.
    #2 clear = 1'b0;
    #1;
    check("rst_ready", {31'd0, instr_ready}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_retired", {16'd0, retired}, 32'd0);
    check("rst_ctl", {26'd0, RAin, RBin, RZin, RAout, RBout, RZout}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    clear = 1'b1;
    #1 check("ready_before_edge", {31'd0, instr_ready}, 32'd0);
    @(posedge clock);
    #1 check("ready_after_edge", {31'd0, instr_ready}, 32'd1);

    // Table-driven transactions through the scoreboard queue.
    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      @(negedge clock);
      instr = v.instr;
      instr_valid = 1'b1;
      o = '{ctl: 6'b0, rega: 32'h0, add: 32'h0, done: 1'b0, err: 1'b0, rdy: 1'b0, ret: exp_ret};
      if (!v.illegal) begin
        o.ctl = v.ctl0; o.rega = v.rega0; o.add = v.add0;
        sb.push_back(o);
        if (v.two_step) begin
          o.ctl = v.ctl1; o.rega = 32'h0; o.add = 32'h0;
          sb.push_back(o);
        end
      end
      o = '{ctl: 6'b0, rega: 32'h0, add: 32'h0, done: 1'b1, err: v.illegal, rdy: 1'b0, ret: exp_ret};
      sb.push_back(o);
      if (!v.illegal) exp_ret = exp_ret + 16'd1;
      o = '{ctl: 6'b0, rega: 32'h0, add: 32'h0, done: 1'b0, err: 1'b0, rdy: 1'b1, ret: exp_ret};
      sb.push_back(o);
      @(posedge clock);
      #1;
      instr_valid = 1'b0;
      instr = $urandom;  // ignored outside IDLE and without valid
      check_obs(sb.pop_front());
      while (sb.size() > 0) begin
        @(posedge clock);
        #1;
        check_obs(sb.pop_front());
      end
      if (i == 1) check("datapath_B", dp_b, 32'd10);
      $display("txn %0d instr=%08h retired=%0d", i, v.instr, retired);
    end

    // Back-to-back NOPs with valid held high: one accept every 3 cycles.
    run_nops(0, 5);
    exp_ret = exp_ret + 16'd5;
    check("b2b_retired", {16'd0, retired}, {16'd0, exp_ret});
    check("b2b_ready", {31'd0, instr_ready}, 32'd1);
    $display("txn b2b nops=5 retired=%0d", retired);

    // Wrap-around on the 3-bit counter instance.
    run_nops(1, 7);
    check("wrap_pre", {29'd0, retired2}, 32'd7);
    run_nops(1, 1);
    check("wrap_zero", {29'd0, retired2}, 32'd0);
    $display("txn wrap retired2=%0d", retired2);

    // Clear asserted mid-T0 of LDIA: controls drop without a clock edge.
    @(negedge clock);
    instr = 32'h1000_0005;
    instr_valid = 1'b1;
    @(posedge clock);
    #1;
    instr_valid = 1'b0;
    check("midrst_RAin_before", {31'd0, RAin}, 32'd1);
    check("midrst_imm_before", RegisterAImmediate, 32'h5);
    #2 clear = 1'b0;
    #1;
    check("midrst_RAin", {31'd0, RAin}, 32'd0);
    check("midrst_imm", RegisterAImmediate, 32'h0);
    check("midrst_retired", {16'd0, retired}, 32'd0);
    check("midrst_ready", {31'd0, instr_ready}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clock);
    clear = 1'b1;
    #1 check("midrst_ready_release", {31'd0, instr_ready}, 32'd0);
    @(posedge clock);
    #1;
    check("midrst_ready_up", {31'd0, instr_ready}, 32'd1);
    check("midrst_no_done", {31'd0, done}, 32'd0);
    $display("txn midreset retired=%0d", retired);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
